mem_port_arbiter: RTL

Shares the single core memory port between the fetch stage's instruction interface and the load/store data interface. It arbitrates requests, keeps the address phase stable until the memory grants it, and tracks outstanding transactions in order so each response returns to the requester that issued it. The block sits between the pipeline and the external memory, on the req/gnt/rvalid protocol used by the fetch stage.

---
 rtl/core_mem_pkg.sv | 14 +
 rtl/mem_id_fifo.sv | 68 ++++++
 rtl/mem_port_arbiter.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/core_mem_pkg.sv
// Types and constants shared by the core memory port logic.
package core_mem_pkg;

  localparam int MEM_AW = 32;
  localparam int MEM_DW = 32;

  localparam logic [3:0] BE_ALL = 4'hF;

  typedef enum logic {
    SRC_INSTR = 1'b0,
    SRC_DATA  = 1'b1
  } mem_src_e;

endpackage

// File: rtl/mem_id_fifo.sv
// In-order FIFO of requester IDs, one entry per granted, still-unanswered
// memory transaction. Pointers wrap modulo DEPTH.
module mem_id_fifo #(
  parameter  int DEPTH = 2,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          din,
  input  logic          pop,
  output logic          head,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          ids [DEPTH];
  logic          do_push;
  logic          do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  assign head  = ids[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  // Entry storage and write pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ids[i] <= 1'b0;
      end
    end else if (do_push) begin
      ids[wr_ptr] <= din;
      wr_ptr      <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
    end
  end

  // Read pointer advances on each accepted pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
    end else if (do_pop) begin
      rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
    end
  end

  // Occupancy; a simultaneous push and pop leaves it unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else begin
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between the fetch (instr) and load/store (data)
// masters. Data normally wins; after STARVE_LIMIT consecutive data grants
// with a waiting fetch, fetch wins once. A stalled address phase is locked
// to its source until granted. Responses are routed in order via an ID FIFO.
module mem_port_arbiter
  import core_mem_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 2,
  parameter int STARVE_LIMIT    = 4
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              instr_req_i,
  input  logic [MEM_AW-1:0] instr_addr_i,
  output logic              instr_gnt_o,
  output logic              instr_rvalid_o,
  output logic [MEM_DW-1:0] instr_rdata_o,
  output logic              instr_err_o,

  input  logic              data_req_i,
  input  logic              data_we_i,
  input  logic [3:0]        data_be_i,
  input  logic [MEM_AW-1:0] data_addr_i,
  input  logic [MEM_DW-1:0] data_wdata_i,
  output logic              data_gnt_o,
  output logic              data_rvalid_o,
  output logic [MEM_DW-1:0] data_rdata_o,
  output logic              data_err_o,

  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [3:0]        mem_be_o,
  output logic [MEM_AW-1:0] mem_addr_o,
  output logic [MEM_DW-1:0] mem_wdata_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic [MEM_DW-1:0] mem_rdata_i,
  input  logic              mem_err_i,

  output logic              busy_o,
  output logic              proto_err_o
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);

  logic          lock_q;
  mem_src_e      lock_src_q;
  logic [SW-1:0] streak_q;

  mem_src_e      sel_src;
  logic          sel_data;
  logic          sel_req;
  logic          grant;

  logic          fifo_pop;
  logic          fifo_head;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;

  // Source select: a locked address phase keeps its source; otherwise data
  // wins unless fetch has been starved for STARVE_LIMIT data grants.
  always_comb begin
    sel_src = SRC_INSTR;
    if (lock_q) begin
      sel_src = lock_src_q;
    end else if (data_req_i && !((streak_q == SW'(STARVE_LIMIT)) && instr_req_i)) begin
      sel_src = SRC_DATA;
    end
  end

  assign sel_data = (sel_src == SRC_DATA);
  assign sel_req  = sel_data ? data_req_i : instr_req_i;

  // The full check uses the registered count, so a pop in the same cycle
  // never frees a slot for a grant until the next cycle.
  assign mem_req_o   = sel_req & ~fifo_full;
  assign grant       = mem_req_o & mem_gnt_i;

  assign mem_we_o    = sel_data ? data_we_i    : 1'b0;
  assign mem_be_o    = sel_data ? data_be_i    : BE_ALL;
  assign mem_addr_o  = sel_data ? data_addr_i  : instr_addr_i;
  assign mem_wdata_o = sel_data ? data_wdata_i : '0;

  assign instr_gnt_o = grant & ~sel_data;
  assign data_gnt_o  = grant &  sel_data;

  // Hold the selected source while its request waits for a grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_q     <= 1'b0;
      lock_src_q <= SRC_INSTR;
    end else if (grant) begin
      lock_q     <= 1'b0;
    end else if (mem_req_o) begin
      lock_q     <= 1'b1;
      lock_src_q <= sel_src;
    end
  end

  // Consecutive data grants while fetch waits, saturating at the limit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      streak_q <= '0;
    end else if (instr_gnt_o || !instr_req_i) begin
      streak_q <= '0;
    end else if (data_gnt_o && (streak_q != SW'(STARVE_LIMIT))) begin
      streak_q <= streak_q + 1'b1;
    end
  end

  assign fifo_pop = mem_rvalid_i & ~fifo_empty;

  mem_id_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_id_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (grant),
    .din   (sel_data),
    .pop   (fifo_pop),
    .head  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign instr_rvalid_o = fifo_pop & (mem_src_e'(fifo_head) == SRC_INSTR);
  assign data_rvalid_o  = fifo_pop & (mem_src_e'(fifo_head) == SRC_DATA);
  assign instr_rdata_o  = mem_rdata_i;
  assign data_rdata_o   = mem_rdata_i;
  assign instr_err_o    = mem_err_i;
  assign data_err_o     = mem_err_i;

  assign busy_o = (fifo_count != '0);

  // Flag a response that arrives with nothing outstanding.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      proto_err_o <= 1'b0;
    end else begin
      proto_err_o <= mem_rvalid_i & fifo_empty;
    end
  end

  // A locked master must keep requesting until its grant.
  a_lock_hold: assert property (@(posedge clk) disable iff (rst) lock_q |-> sel_req);

endmodule
